// File: rtl/freq_meter_if.sv
// Control and result signals of the frequency meter.
// The measuring block uses the slave side; the control side uses master.
interface freq_meter_if #(
  parameter int unsigned CNT_W = 24
);
  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] freq_out;
  logic             valid;
  logic             overflow;
  logic             busy;

  modport master (
    output enable, sig_in,
    input  freq_out, valid, overflow, busy
  );

  modport slave (
    input  enable, sig_in,
    output freq_out, valid, overflow, busy
  );
endinterface

// File: rtl/freq_meter.sv
// Frequency meter: counts synchronized rising edges of sig_in inside a gate
// window of GATE_CYCLES clk_25M cycles and publishes the saturated count.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 25000000,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk_25M,
  input  logic         reset,
  freq_meter_if.slave  bus
);

  localparam int unsigned GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_prev_q, s_prev_d;
  logic [GW-1:0]          gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic                   ovf_i_q, ovf_i_d;
  logic [CNT_W-1:0]       freq_q, freq_d;
  logic                   overflow_q, overflow_d;
  logic                   valid_q, valid_d;

  logic                   s_sync;
  logic                   rise;
  logic                   at_max;
  logic [CNT_W-1:0]       cnt_inc;

  assign s_sync  = sync_q[SYNC_STAGES-1];
  assign rise    = s_sync & ~s_prev_q;
  assign at_max  = (edge_cnt_q == '1);
  assign cnt_inc = at_max ? edge_cnt_q : edge_cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], bus.sig_in};
    // s_prev always tracks s_sync, so entering MEASURE never sees a stale low
    s_prev_d   = s_sync;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_i_d    = ovf_i_q;
    freq_d     = freq_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        ovf_i_d    = 1'b0;
        if (bus.enable) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (!bus.enable) begin
          state_d    = IDLE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_i_d    = 1'b0;
        end else if (gate_cnt_q == GATE_LAST) begin
          // Publish including an edge seen in the closing cycle; restart at once
          freq_d     = rise ? cnt_inc : edge_cnt_q;
          overflow_d = ovf_i_q | (rise & at_max);
          valid_d    = 1'b1;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_i_d    = 1'b0;
        end else begin
          gate_cnt_d = gate_cnt_q + GW'(1);
          if (rise) begin
            edge_cnt_d = cnt_inc;
            if (at_max) begin
              ovf_i_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      s_prev_q   <= 1'b0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_i_q    <= 1'b0;
      freq_q     <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      s_prev_q   <= s_prev_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_i_q    <= ovf_i_d;
      freq_q     <= freq_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.freq_out = freq_q;
  assign bus.overflow = overflow_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = (state_q == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: two instances with a 100-cycle gate,
// one 24-bit and one 4-bit counter, driven by simple square-wave generators.
module tb_freq_meter;

  logic clk;
  logic rst_n;

  freq_meter_if #(.CNT_W(24)) ifa ();
  freq_meter_if #(.CNT_W(4))  ifb ();

  freq_meter #(.GATE_CYCLES(100), .CNT_W(24), .SYNC_STAGES(2)) dut_a (
    .clk_25M (clk),
    .reset   (rst_n),
    .bus     (ifa)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
    .clk_25M (clk),
    .reset   (rst_n),
    .bus     (ifb)
  );

  int total = 0;
  int bad   = 0;

  // Generator controls: period 0 holds lvl, otherwise high for per/2 cycles
  int   per_a = 10, ph_a = 0;
  int   per_b = 0,  ph_b = 0;
  logic lvl_a = 1'b0, lvl_b = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    ifa.sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (per_a == 0) begin
        ifa.sig_in = lvl_a;
      end else begin
        ifa.sig_in = (ph_a < per_a / 2);
        ph_a = (ph_a + 1) % per_a;
      end
    end
  end

  initial begin
    ifb.sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (per_b == 0) begin
        ifb.sig_in = lvl_b;
      end else begin
        ifb.sig_in = (ph_b < per_b / 2);
        ph_b = (ph_b + 1) % per_b;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Counts negedges until valid is seen; -1 if the budget runs out
  task automatic wait_valid(input bit sel, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if ((sel ? ifb.valid : ifa.valid) === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  int n;
  int vc;

  initial begin
    rst_n      = 1'b0;
    ifa.enable = 1'b0;
    ifb.enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_freq_a",  ifa.freq_out, 0);
    check("rst_valid_a", ifa.valid,    0);
    check("rst_ovf_a",   ifa.overflow, 0);
    check("rst_busy_a",  ifa.busy,     0);
    check("rst_freq_b",  ifb.freq_out, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", ifa.busy, 0);

    // Period 10: first result after 101 cycles, then every 100
    ifa.enable = 1'b1;
    @(negedge clk);
    check("t1_busy", ifa.busy, 1);
    wait_valid(1'b0, 200, n);
    check("t1_first_lat", n + 1, 101);
    check("t1_freq", ifa.freq_out, 10);
    check("t1_ovf",  ifa.overflow, 0);
    repeat (2) begin
      wait_valid(1'b0, 200, n);
      check("t1_period", n, 100);
      check("t1_freq_n", ifa.freq_out, 10);
    end

    // Abort at cycle 50 of the window
    repeat (49) @(negedge clk);
    ifa.enable = 1'b0;
    @(negedge clk);
    check("t5_busy_drop", ifa.busy, 0);
    vc = 0;
    repeat (150) begin
      @(negedge clk);
      if (ifa.valid === 1'b1) vc++;
    end
    check("t5_no_valid", vc, 0);
    check("t5_freq_hold", ifa.freq_out, 10);
    ifa.enable = 1'b1;
    wait_valid(1'b0, 200, n);
    check("t5_reen_lat", n, 101);
    check("t5_reen_freq", ifa.freq_out, 10);

    // Period 2: maximum rate
    ifa.enable = 1'b0;
    per_a = 2; ph_a = 0;
    repeat (10) @(negedge clk);
    ifa.enable = 1'b1;
    wait_valid(1'b0, 200, n);
    check("t3_lat", n, 101);
    check("t3_freq", ifa.freq_out, 50);
    wait_valid(1'b0, 200, n);
    check("t3_period", n, 100);
    check("t3_freq_n", ifa.freq_out, 50);

    // Input already high when enabled: no spurious edge
    ifa.enable = 1'b0;
    per_a = 0; lvl_a = 1'b1;
    repeat (10) @(negedge clk);
    ifa.enable = 1'b1;
    wait_valid(1'b0, 200, n);
    check("t2_lat", n, 101);
    check("t2_freq", ifa.freq_out, 0);
    wait_valid(1'b0, 200, n);
    check("t2_period", n, 100);
    check("t2_freq_n", ifa.freq_out, 0);

    // Async reset mid-window, then restart
    ifa.enable = 1'b0;
    per_a = 10; ph_a = 0;
    repeat (10) @(negedge clk);
    ifa.enable = 1'b1;
    wait_valid(1'b0, 200, n);
    check("t6_pre_freq", ifa.freq_out, 10);
    per_a = 0; lvl_a = 1'b0;
    repeat (30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_freq", ifa.freq_out, 0);
    check("t6_rst_ovf",  ifa.overflow, 0);
    check("t6_rst_busy", ifa.busy,     0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    per_a = 10; ph_a = 0;
    wait_valid(1'b0, 200, n);
    check("t6_lat", n, 101);
    check("t6_freq", ifa.freq_out, 10);
    check("t6_ovf",  ifa.overflow, 0);

    // 4-bit counter saturation, then recovery
    ifa.enable = 1'b0;
    per_b = 4; ph_b = 0;
    repeat (10) @(negedge clk);
    ifb.enable = 1'b1;
    wait_valid(1'b1, 200, n);
    check("t4_lat", n, 101);
    check("t4_sat_freq", ifb.freq_out, 15);
    check("t4_sat_ovf",  ifb.overflow, 1);
    per_b = 20; ph_b = 0;
    wait_valid(1'b1, 200, n);
    check("t4_mix_period", n, 100);
    wait_valid(1'b1, 200, n);
    check("t4_period", n, 100);
    check("t4_freq", ifb.freq_out, 5);
    check("t4_ovf",  ifb.overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
